// File: rtl/rpn_pkg.sv
// rtl/rpn_pkg.sv - shared types and constants for the RPN stack calculator
package rpn_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_OR   = 3'b010,
        OP_AND  = 3'b011,
        OP_XOR  = 3'b100,
        OP_DUP  = 3'b101,
        OP_SWAP = 3'b110,
        OP_DROP = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_ERROR = 2'd2
    } state_e;

    // Bit positions inside the 5-bit {N,Z,C,V,P} flag word
    localparam int FLAG_N = 4;
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_P = 0;

    // Bit positions inside the 3-bit {Error,Full,Empty} status word
    localparam int STAT_ERROR = 2;
    localparam int STAT_FULL  = 1;
    localparam int STAT_EMPTY = 0;

endpackage

// File: rtl/rpn_alu.sv
// rtl/rpn_alu.sv - combinational two-operand ALU with N/Z/C/V/P flag generation
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  opcode_e          opcode_i,
    output logic [WIDTH-1:0] res_o,
    output logic [4:0]       flags_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           carry;
    logic           ovf;

    // Subtraction is A + ~B + 1, so its carry out is the "no borrow" indication
    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};

    // Result select plus flag derivation; stack-shuffle opcodes produce nothing useful here
    always_comb begin
        res_o = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (opcode_i)
            OP_ADD: begin
                res_o = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB: begin
                res_o = diff[WIDTH-1:0];
                carry = diff[WIDTH];
                ovf   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_OR:   res_o = a_i | b_i;
            OP_AND:  res_o = a_i & b_i;
            OP_XOR:  res_o = a_i ^ b_i;
            default: res_o = '0;
        endcase
        flags_o         = '0;
        flags_o[FLAG_N] = res_o[WIDTH-1];
        flags_o[FLAG_Z] = (res_o == '0);
        flags_o[FLAG_C] = carry;
        flags_o[FLAG_V] = ovf;
        flags_o[FLAG_P] = ^res_o;
    end

endmodule

// File: rtl/rpn_stack_calc.sv
// rtl/rpn_stack_calc.sv - RPN calculator core: operand stack, FSM, legality check, one-level undo
module rpn_stack_calc
    import rpn_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       EnterPulse,
    input  logic                       UndoPulse,
    input  logic                       OpMode,
    input  logic [WIDTH-1:0]           DataIn,
    output logic [31:0]                ToDisplay,
    output logic [WIDTH-1:0]           Top,
    output logic [$clog2(DEPTH+1)-1:0] Depth,
    output logic [4:0]                 Flags,
    output logic [2:0]                 Status
);

    localparam int             DW      = $clog2(DEPTH + 1);
    localparam logic [DW-1:0]  DEPTH_C = DW'(DEPTH);
    localparam logic [DW-1:0]  TWO_C   = DW'(2);

    state_e           state_q, state_d;
    logic             cmd_undo_q, cmd_undo_d;
    logic             cmd_mode_q, cmd_mode_d;
    logic [WIDTH-1:0] cmd_data_q, cmd_data_d;

    logic [WIDTH-1:0] stack_q  [DEPTH];
    logic [WIDTH-1:0] stack_d  [DEPTH];
    logic [WIDTH-1:0] shadow_q [DEPTH];
    logic [WIDTH-1:0] shadow_d [DEPTH];
    logic [DW-1:0]    depth_q, depth_d;
    logic [DW-1:0]    shadow_depth_q, shadow_depth_d;
    logic [4:0]       flags_q, flags_d;
    logic [4:0]       shadow_flags_q, shadow_flags_d;
    logic             undo_valid_q, undo_valid_d;

    opcode_e          cmd_op;
    logic             cmd_legal;
    logic             any_pulse;
    logic             commit;
    logic             restore;
    logic [WIDTH-1:0] alu_res;
    logic [4:0]       alu_flags;

    assign cmd_op    = opcode_e'(cmd_data_q[2:0]);
    assign any_pulse = EnterPulse | UndoPulse;
    assign commit    = (state_q == S_EXEC) && !cmd_undo_q && cmd_legal;
    assign restore   = (state_q == S_EXEC) && cmd_undo_q && undo_valid_q;

    rpn_alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .a_i      (stack_q[1]),
        .b_i      (stack_q[0]),
        .opcode_i (cmd_op),
        .res_o    (alu_res),
        .flags_o  (alu_flags)
    );

    // Legality of the latched Enter command against the current stack depth
    always_comb begin
        cmd_legal = 1'b0;
        if (!cmd_mode_q) begin
            cmd_legal = (depth_q != DEPTH_C);
        end else begin
            case (cmd_op)
                OP_DUP:  cmd_legal = (depth_q != '0) && (depth_q != DEPTH_C);
                OP_DROP: cmd_legal = (depth_q != '0);
                default: cmd_legal = (depth_q >= TWO_C);
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: pulses arriving in EXEC are ignored, ERROR is left by any pulse
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_pulse) state_d = S_EXEC;
            S_EXEC:  state_d = (!cmd_undo_q && !cmd_legal) ? S_ERROR : S_IDLE;
            S_ERROR: if (any_pulse) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: status and display words, all from registers except the empty-stack display
    always_comb begin
        Status             = '0;
        Status[STAT_ERROR] = (state_q == S_ERROR);
        Status[STAT_FULL]  = (depth_q == DEPTH_C);
        Status[STAT_EMPTY] = (depth_q == '0);
        Top                = stack_q[0];
        Depth              = depth_q;
        Flags              = flags_q;
        ToDisplay          = (depth_q == '0) ? 32'(DataIn) : 32'(stack_q[0]);
    end

    // Datapath next state: command latch, undo restore, snapshot-then-commit
    always_comb begin
        cmd_undo_d     = cmd_undo_q;
        cmd_mode_d     = cmd_mode_q;
        cmd_data_d     = cmd_data_q;
        stack_d        = stack_q;
        shadow_d       = shadow_q;
        depth_d        = depth_q;
        shadow_depth_d = shadow_depth_q;
        flags_d        = flags_q;
        shadow_flags_d = shadow_flags_q;
        undo_valid_d   = undo_valid_q;

        if ((state_q == S_IDLE) && any_pulse) begin
            cmd_undo_d = UndoPulse;
            cmd_mode_d = OpMode;
            cmd_data_d = DataIn;
        end

        if (restore) begin
            stack_d      = shadow_q;
            depth_d      = shadow_depth_q;
            flags_d      = shadow_flags_q;
            undo_valid_d = 1'b0;
        end else if (commit) begin
            shadow_d       = stack_q;
            shadow_depth_d = depth_q;
            shadow_flags_d = flags_q;
            undo_valid_d   = 1'b1;
            if (!cmd_mode_q) begin
                for (int i = 1; i < DEPTH; i++) stack_d[i] = stack_q[i-1];
                stack_d[0] = cmd_data_q;
                depth_d    = depth_q + DW'(1);
            end else begin
                case (cmd_op)
                    OP_DUP: begin
                        for (int i = 1; i < DEPTH; i++) stack_d[i] = stack_q[i-1];
                        depth_d = depth_q + DW'(1);
                    end
                    OP_SWAP: begin
                        stack_d[0] = stack_q[1];
                        stack_d[1] = stack_q[0];
                    end
                    OP_DROP: begin
                        for (int i = 0; i < DEPTH - 1; i++) stack_d[i] = stack_q[i+1];
                        stack_d[DEPTH-1] = '0;
                        depth_d          = depth_q - DW'(1);
                    end
                    default: begin
                        stack_d[0] = alu_res;
                        for (int i = 1; i < DEPTH - 1; i++) stack_d[i] = stack_q[i+1];
                        stack_d[DEPTH-1] = '0;
                        depth_d          = depth_q - DW'(1);
                        flags_d          = alu_flags;
                    end
                endcase
            end
        end
    end

    // Datapath registers; an asynchronous reset mid-EXEC discards the pending command
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cmd_undo_q     <= 1'b0;
            cmd_mode_q     <= 1'b0;
            cmd_data_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i]  <= '0;
                shadow_q[i] <= '0;
            end
            depth_q        <= '0;
            shadow_depth_q <= '0;
            flags_q        <= '0;
            shadow_flags_q <= '0;
            undo_valid_q   <= 1'b0;
        end else begin
            cmd_undo_q     <= cmd_undo_d;
            cmd_mode_q     <= cmd_mode_d;
            cmd_data_q     <= cmd_data_d;
            stack_q        <= stack_d;
            shadow_q       <= shadow_d;
            depth_q        <= depth_d;
            shadow_depth_q <= shadow_depth_d;
            flags_q        <= flags_d;
            shadow_flags_q <= shadow_flags_d;
            undo_valid_q   <= undo_valid_d;
        end
    end

endmodule

// File: tb/tb_rpn_stack_calc.sv
// tb/tb_rpn_stack_calc.sv - randomized self-checking bench for rpn_stack_calc against a queue model
module tb_rpn_stack_calc;

    logic        clk = 1'b0;
    logic        resetN;
    logic        EnterPulse;
    logic        UndoPulse;
    logic        OpMode;
    logic [15:0] DataIn;
    logic [31:0] ToDisplay;
    logic [15:0] Top;
    logic [2:0]  Depth;
    logic [4:0]  Flags;
    logic [2:0]  Status;

    int checks = 0;
    int errors = 0;

    // Reference model: queue front is the top of stack
    logic [15:0] ms[$];
    logic [15:0] ss[$];
    logic [4:0]  mf;
    logic [4:0]  sf;
    bit          merr;
    bit          muv;

    always #5 clk = ~clk;

    rpn_stack_calc #(.WIDTH(16), .DEPTH(4)) dut (
        .clk        (clk),
        .resetN     (resetN),
        .EnterPulse (EnterPulse),
        .UndoPulse  (UndoPulse),
        .OpMode     (OpMode),
        .DataIn     (DataIn),
        .ToDisplay  (ToDisplay),
        .Top        (Top),
        .Depth      (Depth),
        .Flags      (Flags),
        .Status     (Status)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [58:0] obs_vec();
        return {Top, Depth, Flags, Status, ToDisplay};
    endfunction

    function automatic logic [58:0] exp_vec();
        int          n = ms.size();
        logic [15:0] t = (n > 0) ? ms[0] : 16'h0000;
        logic [2:0]  st = {merr, (n == 4), (n == 0)};
        logic [31:0] td = (n > 0) ? {16'h0000, ms[0]} : {16'h0000, DataIn};
        return {t, 3'(n), mf, st, td};
    endfunction

    task automatic model_reset();
        ms.delete();
        ss.delete();
        mf   = '0;
        sf   = '0;
        merr = 1'b0;
        muv  = 1'b0;
    endtask

    task automatic model_alu(input logic [2:0] code, input logic [15:0] a, input logic [15:0] b,
                             output logic [15:0] res, output logic [4:0] fl);
        int ua = int'(a);
        int ub = int'(b);
        int sa = $signed(a);
        int sb = $signed(b);
        int r  = 0;
        int sr = 0;
        bit c  = 1'b0;
        bit v  = 1'b0;
        case (code)
            3'd0: begin r = ua + ub; c = (r > 65535); sr = sa + sb; v = (sr > 32767) || (sr < -32768); end
            3'd1: begin r = ua - ub; c = (ua >= ub);  sr = sa - sb; v = (sr > 32767) || (sr < -32768); end
            3'd2: r = ua | ub;
            3'd3: r = ua & ub;
            default: r = ua ^ ub;
        endcase
        res = 16'(r);
        fl  = {res[15], (res == 16'h0000), c, v, ^res};
    endtask

    task automatic model_cmd(input bit undo, input bit mode, input logic [15:0] d);
        logic [15:0] r;
        logic [4:0]  fl;
        logic [15:0] tmp;
        int          n = ms.size();
        if (merr) begin
            merr = 1'b0;
            return;
        end
        if (undo) begin
            if (muv) begin
                ms  = ss;
                mf  = sf;
                muv = 1'b0;
            end
            return;
        end
        if (!mode) begin
            if (n == 4) begin merr = 1'b1; return; end
            ss = ms; sf = mf; muv = 1'b1;
            ms.push_front(d);
            return;
        end
        case (d[2:0])
            3'd5: begin
                if (n == 0 || n == 4) begin merr = 1'b1; return; end
                ss = ms; sf = mf; muv = 1'b1;
                ms.push_front(ms[0]);
            end
            3'd6: begin
                if (n < 2) begin merr = 1'b1; return; end
                ss = ms; sf = mf; muv = 1'b1;
                tmp = ms[0]; ms[0] = ms[1]; ms[1] = tmp;
            end
            3'd7: begin
                if (n == 0) begin merr = 1'b1; return; end
                ss = ms; sf = mf; muv = 1'b1;
                void'(ms.pop_front());
            end
            default: begin
                if (n < 2) begin merr = 1'b1; return; end
                ss = ms; sf = mf; muv = 1'b1;
                model_alu(d[2:0], ms[1], ms[0], r, fl);
                void'(ms.pop_front());
                void'(ms.pop_front());
                ms.push_front(r);
                mf = fl;
            end
        endcase
    endtask

    // One command: pulse for one cycle, then one idle cycle; returns at a falling edge
    task automatic drive(input bit u, input bit e, input bit mode, input logic [15:0] d);
        UndoPulse  = u;
        EnterPulse = e;
        OpMode     = mode;
        DataIn     = d;
        @(negedge clk);
        UndoPulse  = 1'b0;
        EnterPulse = 1'b0;
        @(negedge clk);
        if (u || e) model_cmd(u, mode, d);
    endtask

    function automatic logic [15:0] opword(input logic [2:0] code);
        logic [15:0] w = 16'($urandom);
        return {w[15:3], code};
    endfunction

    task automatic reset_dut();
        resetN     = 1'b0;
        EnterPulse = 1'b0;
        UndoPulse  = 1'b0;
        OpMode     = 1'b0;
        DataIn     = 16'($urandom);
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        model_reset();
    endtask

    task automatic test_reset();
        reset_dut();
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", obs_vec(), exp_vec());
        end
        checks++;
        if (Status !== 3'b001 || ToDisplay !== {16'h0000, DataIn}) begin
            errors++;
            $display("FAIL reset_status_display: got status %b display %h want 001 %h", Status, ToDisplay, {16'h0000, DataIn});
        end
    endtask

    task automatic test_arith();
        reset_dut();
        drive(0, 1, 0, 16'h0003);
        drive(0, 1, 0, 16'h0005);
        drive(0, 1, 1, opword(3'd0));
        checks++;
        if (Top !== 16'h0008 || Depth !== 3'd1 || Flags !== 5'b00001 || Status !== 3'b000) begin
            errors++;
            $display("FAIL add_small: got top %h depth %0d flags %b status %b want 0008 1 00001 000", Top, Depth, Flags, Status);
        end
        reset_dut();
        drive(0, 1, 0, 16'h8000);
        drive(0, 1, 0, 16'h8000);
        drive(0, 1, 1, opword(3'd0));
        checks++;
        if (Top !== 16'h0000 || Flags !== 5'b01110) begin
            errors++;
            $display("FAIL add_overflow: got top %h flags %b want 0000 01110", Top, Flags);
        end
        drive(1, 0, 0, 16'h1234);
        checks++;
        if (Depth !== 3'd2 || Top !== 16'h8000 || Flags !== 5'b00000) begin
            errors++;
            $display("FAIL undo_after_add: got depth %0d top %h flags %b want 2 8000 00000", Depth, Top, Flags);
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL arith_model: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_error();
        reset_dut();
        drive(0, 1, 0, 16'h0001);
        drive(0, 1, 0, 16'h0002);
        drive(0, 1, 1, opword(3'd1));
        checks++;
        if (Top !== 16'hFFFF || Flags[4] !== 1'b1 || Flags[2] !== 1'b0) begin
            errors++;
            $display("FAIL sub_negative: got top %h flags %b want ffff N=1 C=0", Top, Flags);
        end
        drive(0, 1, 1, opword(3'd6));
        checks++;
        if (Status !== 3'b100 || Top !== 16'hFFFF || Depth !== 3'd1) begin
            errors++;
            $display("FAIL swap_underflow: got status %b top %h depth %0d want 100 ffff 1", Status, Top, Depth);
        end
        drive(0, 1, 0, 16'h0077);
        checks++;
        if (Status !== 3'b000 || Top !== 16'hFFFF || Depth !== 3'd1) begin
            errors++;
            $display("FAIL error_clear: got status %b top %h depth %0d want 000 ffff 1", Status, Top, Depth);
        end
    endtask

    task automatic test_full();
        reset_dut();
        for (int i = 1; i <= 4; i++) drive(0, 1, 0, 16'(i));
        checks++;
        if (Status !== 3'b010 || Depth !== 3'd4) begin
            errors++;
            $display("FAIL full_status: got status %b depth %0d want 010 4", Status, Depth);
        end
        drive(0, 1, 0, 16'h0005);
        checks++;
        if (Status !== 3'b110 || Top !== 16'h0004 || Depth !== 3'd4) begin
            errors++;
            $display("FAIL push_overflow: got status %b top %h depth %0d want 110 0004 4", Status, Top, Depth);
        end
        drive(0, 1, 0, 16'h0006);
        drive(0, 1, 1, opword(3'd5));
        checks++;
        if (Status !== 3'b110) begin
            errors++;
            $display("FAIL dup_full: got status %b want 110", Status);
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL full_model: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_undo();
        reset_dut();
        drive(0, 1, 0, 16'h0009);
        drive(0, 1, 0, 16'h000A);
        drive(1, 0, 0, 16'h0000);
        checks++;
        if (Depth !== 3'd1 || Top !== 16'h0009) begin
            errors++;
            $display("FAIL undo_first: got depth %0d top %h want 1 0009", Depth, Top);
        end
        drive(1, 0, 0, 16'h0000);
        checks++;
        if (Depth !== 3'd1 || Top !== 16'h0009 || Status !== 3'b000) begin
            errors++;
            $display("FAIL undo_second_noop: got depth %0d top %h status %b want 1 0009 000", Depth, Top, Status);
        end
        drive(0, 1, 0, 16'h0022);
        drive(1, 1, 0, 16'h0055);
        checks++;
        if (Depth !== 3'd1 || Top !== 16'h0009) begin
            errors++;
            $display("FAIL undo_wins: got depth %0d top %h want 1 0009", Depth, Top);
        end
    endtask

    task automatic test_back_to_back();
        reset_dut();
        // second pulse lands in the EXEC cycle of the first and must be dropped
        EnterPulse = 1'b1;
        OpMode     = 1'b0;
        DataIn     = 16'h00A1;
        @(negedge clk);
        DataIn = 16'h00B2;
        @(negedge clk);
        EnterPulse = 1'b0;
        model_cmd(0, 0, 16'h00A1);
        drive(0, 1, 0, 16'h00C3);
        checks++;
        if (Depth !== 3'd2 || Top !== 16'h00C3) begin
            errors++;
            $display("FAIL exec_pulse_drop: got depth %0d top %h want 2 00c3", Depth, Top);
        end
        drive(0, 1, 1, opword(3'd7));
        checks++;
        if (Top !== 16'h00A1 || Depth !== 3'd1) begin
            errors++;
            $display("FAIL latched_data: got top %h depth %0d want 00a1 1", Top, Depth);
        end
    endtask

    task automatic test_random();
        int          sel;
        logic [15:0] d;
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            d   = 16'($urandom);
            if (sel < 2)       drive(1, 0, 0, d);
            else if (sel == 2) drive(1, 1, 0, d);
            else if (sel < 6)  drive(0, 1, 0, d);
            else               drive(0, 1, 1, d);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_step %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid_exec();
        reset_dut();
        drive(0, 1, 0, 16'h0003);
        drive(0, 1, 0, 16'h0005);
        drive(0, 1, 1, opword(3'd0));
        EnterPulse = 1'b1;
        OpMode     = 1'b0;
        DataIn     = 16'h0042;
        @(negedge clk);
        EnterPulse = 1'b0;
        resetN     = 1'b0;
        #2;
        checks++;
        if (Depth !== 3'd0 || Status !== 3'b001 || Flags !== 5'b00000 || Top !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset: got depth %0d status %b flags %b top %h want 0 001 00000 0000", Depth, Status, Flags, Top);
        end
        @(negedge clk);
        resetN = 1'b1;
        DataIn = 16'($urandom);
        @(negedge clk);
        model_reset();
        checks++;
        if (obs_vec() !== exp_vec() || ToDisplay !== {16'h0000, DataIn}) begin
            errors++;
            $display("FAIL reset_release: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_error();
        test_full();
        test_undo();
        test_back_to_back();
        test_random();
        test_reset_mid_exec();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
